// File: rtl/vector_load_store_unit.sv
// Vector load/store unit: turns one LANES-element vector access into a sequence
// of single-element memory accesses, with a byte stride, a lane mask and ready handshake.
module vector_load_store_unit #(
   parameter int unsigned LANES  = 4,
   parameter int unsigned ELEM_W = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    vector_op,
   input  logic                    is_store,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic [ADDR_W-1:0]       stride,
   input  logic [LANES-1:0]        lane_mask,
   input  logic [LANES*ELEM_W-1:0] in_writedata,
   input  logic [ELEM_W-1:0]       mem_readdata,
   input  logic                    mem_ready,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [ELEM_W-1:0]       mem_writedata,
   output logic                    stall,
   output logic                    done,
   output logic [LANES*ELEM_W-1:0] out_readdata
);

   localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e                  state_q, state_d;
   logic                    is_store_q, is_store_d;
   logic [ADDR_W-1:0]       base_q, base_d;
   logic [ADDR_W-1:0]       stride_q, stride_d;
   logic [LANES*ELEM_W-1:0] wdata_q, wdata_d;
   logic [LANES-1:0]        mask_q, mask_d;
   logic [LaneW-1:0]        lane_q, lane_d;
   logic [LANES*ELEM_W-1:0] rdata_q, rdata_d;

   logic [LANES-1:0]  eff_mask;
   logic [LaneW-1:0]  first_lane;
   logic              first_found;
   logic [LaneW-1:0]  next_lane;
   logic              has_next;
   logic [ELEM_W-1:0] lane_wdata;
   logic [ADDR_W-1:0] lane_addr;

   // Lane search: lowest enabled lane at start, next enabled lane above the current one.
   always_comb begin
      eff_mask    = vector_op ? lane_mask : LANES'(1);
      first_lane  = '0;
      first_found = 1'b0;
      next_lane   = '0;
      has_next    = 1'b0;
      lane_wdata  = '0;
      for (int i = 0; i < LANES; i++) begin
         if (!first_found && eff_mask[i]) begin
            first_lane  = LaneW'(i);
            first_found = 1'b1;
         end
         if (!has_next && mask_q[i] && (LaneW'(i) > lane_q)) begin
            next_lane = LaneW'(i);
            has_next  = 1'b1;
         end
         if (lane_q == LaneW'(i)) begin
            lane_wdata = wdata_q[i*ELEM_W +: ELEM_W];
         end
      end
   end

   assign lane_addr = base_q + ADDR_W'(lane_q) * stride_q;

   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      base_d     = base_q;
      stride_d   = stride_q;
      wdata_d    = wdata_q;
      mask_d     = mask_q;
      lane_d     = lane_q;
      rdata_d    = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               is_store_d = is_store;
               base_d     = base_addr;
               stride_d   = stride;
               wdata_d    = in_writedata;
               mask_d     = eff_mask;
               lane_d     = first_lane;
               if (!is_store) rdata_d = '0;
               state_d = first_found ? StAccess : StDone;
            end
         end
         StAccess: begin
            if (mem_ready) begin
               if (!is_store_q) begin
                  for (int i = 0; i < LANES; i++) begin
                     if (lane_q == LaneW'(i)) rdata_d[i*ELEM_W +: ELEM_W] = mem_readdata;
                  end
               end
               if (has_next) begin
                  lane_d = next_lane;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         is_store_q <= 1'b0;
         base_q     <= '0;
         stride_q   <= '0;
         wdata_q    <= '0;
         mask_q     <= '0;
         lane_q     <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         base_q     <= base_d;
         stride_q   <= stride_d;
         wdata_q    <= wdata_d;
         mask_q     <= mask_d;
         lane_q     <= lane_d;
         rdata_q    <= rdata_d;
      end
   end

   always_comb begin
      mem_req       = (state_q == StAccess);
      mem_we        = mem_req & is_store_q;
      mem_addr      = mem_req ? lane_addr : '0;
      mem_writedata = (mem_req && is_store_q) ? lane_wdata : '0;
      stall         = mem_req | ((state_q == StIdle) & start);
      done          = (state_q == StDone);
      out_readdata  = rdata_q;
   end

endmodule

// File: tb/tb_vector_load_store_unit.sv
// Bench for vector_load_store_unit: a queue-of-accesses reference model checked
// every cycle, plus directed cases with hand-computed literal expectations.
module tb_vector_load_store_unit;

   localparam int LANES  = 4;
   localparam int ELEM_W = 32;
   localparam int ADDR_W = 32;
   localparam int DW     = LANES * ELEM_W;

   logic              clk;
   logic              reset;
   logic              start;
   logic              vector_op;
   logic              is_store;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] stride;
   logic [LANES-1:0]  lane_mask;
   logic [DW-1:0]     in_writedata;
   logic [ELEM_W-1:0] mem_readdata;
   logic              mem_ready;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [ELEM_W-1:0] mem_writedata;
   logic              stall;
   logic              done;
   logic [DW-1:0]     out_readdata;

   vector_load_store_unit #(
      .LANES  (LANES),
      .ELEM_W (ELEM_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .vector_op     (vector_op),
      .is_store      (is_store),
      .base_addr     (base_addr),
      .stride        (stride),
      .lane_mask     (lane_mask),
      .in_writedata  (in_writedata),
      .mem_readdata  (mem_readdata),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_writedata (mem_writedata),
      .stall         (stall),
      .done          (done),
      .out_readdata  (out_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an operation is the list of accesses it must perform.
   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [ELEM_W-1:0] wdata;
      int                lane;
   } acc_t;

   acc_t          acc_q[$];
   logic          done_due    = 1'b0;
   logic          model_valid = 1'b0;
   logic [DW-1:0] m_rdata     = '0;
   logic          m_busy;
   logic          m_idle;
   logic [LANES-1:0] m_mask;
   acc_t          m_acc;

   always @(negedge clk) begin
      if (model_valid) begin
         m_busy = (acc_q.size() > 0);
         m_idle = !m_busy && !done_due;
         if (m_busy) begin
            check("mem_req", 256'(mem_req), 256'(1'b1));
            check("mem_we", 256'(mem_we), 256'(acc_q[0].we));
            check("mem_addr", 256'(mem_addr), 256'(acc_q[0].addr));
            check("mem_writedata", 256'(mem_writedata), 256'(acc_q[0].wdata));
         end else begin
            check("mem_req_idle", 256'(mem_req), 256'(1'b0));
            check("mem_bus_idle", 256'({mem_we, mem_addr, mem_writedata}), 256'(0));
         end
         check("stall", 256'(stall), 256'(m_busy | (m_idle & start)));
         check("done", 256'(done), 256'(done_due));
         check("out_readdata", 256'(out_readdata), 256'(m_rdata));
      end
      if (reset) begin
         acc_q.delete();
         done_due    = 1'b0;
         m_rdata     = '0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         if (done_due) begin
            done_due = 1'b0;
         end else if (acc_q.size() > 0) begin
            if (mem_ready) begin
               if (!acc_q[0].we) m_rdata[acc_q[0].lane*ELEM_W +: ELEM_W] = mem_readdata;
               void'(acc_q.pop_front());
               if (acc_q.size() == 0) done_due = 1'b1;
            end
         end else if (start) begin
            m_mask = vector_op ? lane_mask : LANES'(1);
            if (!is_store) m_rdata = '0;
            for (int i = 0; i < LANES; i++) begin
               if (m_mask[i]) begin
                  m_acc.addr  = base_addr + ADDR_W'(i) * stride;
                  m_acc.we    = is_store;
                  m_acc.wdata = is_store ? in_writedata[i*ELEM_W +: ELEM_W] : '0;
                  m_acc.lane  = i;
                  acc_q.push_back(m_acc);
               end
            end
            if (acc_q.size() == 0) done_due = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic vop, input logic st, input logic [ADDR_W-1:0] b,
                         input logic [ADDR_W-1:0] s, input logic [LANES-1:0] m,
                         input logic [DW-1:0] wd);
      start        = 1'b1;
      vector_op    = vop;
      is_store     = st;
      base_addr    = b;
      stride       = s;
      lane_mask    = m;
      in_writedata = wd;
   endtask

   // Runs until done with random ready/readdata and stray start pulses; bounded.
   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done !== 1'b1) begin
         if (n == budget) begin
            n_fail++;
            $display("FAIL wait_done: got no done expected done within %0d cycles", budget);
            return;
         end
         mem_ready    = ($urandom_range(0, 9) < 7);
         mem_readdata = $urandom;
         start        = ($urandom_range(0, 7) == 0);
         base_addr    = $urandom;
         tick();
         n++;
      end
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      vector_op = 1'b0;
      is_store = 1'b0;
      base_addr = '0;
      stride = '0;
      lane_mask = '0;
      in_writedata = '0;
      mem_readdata = '0;
      mem_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("reset_outputs", 256'({mem_req, mem_we, mem_addr, mem_writedata, stall, done}),
            256'(0));
      check("reset_rdata", 256'(out_readdata), 256'(0));

      // Vector load, all lanes, ready held high.
      set_op(1'b1, 1'b0, 32'h100, 32'd4, 4'b1111, '0);
      mem_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_readdata = 32'hA0 + 32'(k);
         check("vload_addr", 256'(mem_addr), 256'(32'h100 + 32'(4 * k)));
         tick();
      end
      check("vload_done_t5", 256'(done), 256'(1'b1));
      check("vload_rdata", 256'(out_readdata), 256'(128'h000000A3_000000A2_000000A1_000000A0));
      tick();

      // Strided negative store, lanes 1 and 3, two wait cycles on the first access.
      set_op(1'b1, 1'b1, 32'h200, 32'hFFFF_FFF8, 4'b1010,
             128'h44444444_33333333_22222222_11111111);
      mem_ready = 1'b0;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) mem_ready = 1'b1;
         check("vstore_addr1", 256'({mem_we, mem_addr, mem_writedata}),
               256'({1'b1, 32'h1F8, 32'h22222222}));
         check("vstore_stall", 256'(stall), 256'(1'b1));
         tick();
      end
      check("vstore_addr3", 256'({mem_we, mem_addr, mem_writedata}),
            256'({1'b1, 32'h1E8, 32'h44444444}));
      tick();
      check("vstore_done", 256'(done), 256'(1'b1));
      check("vstore_rdata_kept", 256'(out_readdata),
            256'(128'h000000A3_000000A2_000000A1_000000A0));
      tick();

      // Scalar load at top of address space; mask is ignored.
      set_op(1'b0, 1'b0, 32'hFFFF_FFFC, $urandom, 4'b0000, '0);
      mem_ready    = 1'b1;
      mem_readdata = 32'hDEADBEEF;
      tick();
      start = 1'b0;
      check("scalar_addr", 256'({mem_req, mem_addr}), 256'({1'b1, 32'hFFFF_FFFC}));
      tick();
      check("scalar_done", 256'(done), 256'(1'b1));
      check("scalar_rdata", 256'(out_readdata), 256'(128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF));
      tick();

      // Empty mask: no access, done right after start.
      set_op(1'b1, 1'b0, 32'h40, 32'd4, 4'b0000, '0);
      tick();
      start = 1'b0;
      check("nomask_done", 256'({done, mem_req}), 256'({1'b1, 1'b0}));
      tick();

      // Second start during ACCESS must not disturb the running op.
      set_op(1'b1, 1'b0, 32'h500, 32'd16, 4'b0011, '0);
      mem_ready = 1'b0;
      tick();
      set_op(1'b1, 1'b1, 32'h999, 32'd1, 4'b1111, '1);
      tick();
      check("ignored_start_addr", 256'({mem_we, mem_addr}), 256'({1'b0, 32'h500}));
      tick();
      start = 1'b0;
      mem_ready = 1'b1;
      tick();
      check("ignored_start_lane1", 256'({mem_we, mem_addr}), 256'({1'b0, 32'h510}));
      wait_done(50);
      tick();

      // Reset during the second lane of a vector load.
      set_op(1'b1, 1'b0, 32'h300, 32'd4, 4'b1111, '0);
      mem_ready    = 1'b1;
      mem_readdata = 32'h1234_5678;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midreset_req", 256'({mem_req, stall, done}), 256'(0));
      check("midreset_rdata", 256'(out_readdata), 256'(0));

      // Randomised operations.
      for (int t = 0; t < 60; t++) begin
         set_op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
                ($urandom_range(0, 3) == 0) ? $urandom : 32'(4 * ($urandom_range(0, 8) - 4)),
                LANES'($urandom), {$urandom, $urandom, $urandom, $urandom});
         mem_ready    = ($urandom_range(0, 9) < 7);
         mem_readdata = $urandom;
         tick();
         start = 1'b0;
         wait_done(100);
         tick();
         if ($urandom_range(0, 2) == 0) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
